// File: rtl/ssg_bus_master_if.sv
// rtl/ssg_bus_master_if.sv - SSG I/O bus (bus_io_req/bus_ack) with initiator and responder views
interface ssg_bus_master_if;
    logic        bus_io_req;
    logic        bus_ack;
    logic        bus_wrt;
    logic [15:0] bus_address;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_rdata_en;

    modport master (
        output bus_io_req, bus_wrt, bus_address, bus_wdata,
        input  bus_ack, bus_rdata, bus_rdata_en
    );

    modport slave (
        input  bus_io_req, bus_wrt, bus_address, bus_wdata,
        output bus_ack, bus_rdata, bus_rdata_en
    );
endinterface

// File: rtl/ssg_bus_master.sv
// rtl/ssg_bus_master.sv - SSG register-access bus initiator with command FIFO; abort on timeout with SSG_BUS_MASTER_TIMEOUT_EN
module ssg_bus_master #(
    parameter logic [15:0] IO_BASE    = 16'h00A0,
    parameter int          FIFO_DEPTH = 4,
    parameter int          TIMEOUT    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_wrt,
    input  logic [3:0]         cmd_reg,
    input  logic [7:0]         cmd_wdata,
    output logic               rsp_valid,
    output logic [7:0]         rsp_rdata,
    output logic               rsp_error,
    output logic               busy,
    ssg_bus_master_if.master   bus
);
    localparam int             AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL_COUNT = FIFO_DEPTH[AW:0];

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("ssg_bus_master: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {IDLE, ADDR_REQ, ADDR_GAP, DATA_REQ, READ_WAIT, DONE} state_t;
    state_t state, state_nxt;

    logic [12:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    logic [12:0]   cmd_q;
    logic [7:0]    rdata_q;
    logic          capture, abort;

    wire       q_wrt   = cmd_q[12];
    wire [3:0] q_reg   = cmd_q[11:8];
    wire [7:0] q_wdata = cmd_q[7:0];

    assign cmd_ready = (count != FULL_COUNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_wrt, cmd_reg, cmd_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Read data is only meaningful once the data-phase ack has been seen.
    assign capture = bus.bus_rdata_en &&
                     (((state == DATA_REQ) && bus.bus_ack && !q_wrt) || (state == READ_WAIT));

`ifdef SSG_BUS_MASTER_TIMEOUT_EN
    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_cnt;
    logic          waiting, err_q;

    assign waiting = (state == ADDR_REQ) || (state == DATA_REQ) || (state == READ_WAIT);
    assign abort   = waiting && (tmo_cnt == TMO_LAST) &&
                     ((state == READ_WAIT) ? !bus.bus_rdata_en : !bus.bus_ack);

    always_ff @(posedge clk) begin
        if (reset || (state_nxt != state)) tmo_cnt <= '0;
        else if (waiting)                  tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || pop) err_q <= 1'b0;
        else if (abort)   err_q <= 1'b1;
    end
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q   <= '0;
            rdata_q <= '0;
        end else if (pop) begin
            cmd_q   <= fifo_mem[rd_ptr];
            rdata_q <= '0;
        end else if (capture) begin
            rdata_q <= bus.bus_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (count != '0) state_nxt = ADDR_REQ;
            ADDR_REQ:  if (bus.bus_ack) state_nxt = ADDR_GAP;
                       else if (abort)  state_nxt = DONE;
            ADDR_GAP:  state_nxt = DATA_REQ;
            DATA_REQ:  if (bus.bus_ack) state_nxt = (q_wrt || bus.bus_rdata_en) ? DONE : READ_WAIT;
                       else if (abort)  state_nxt = DONE;
            READ_WAIT: if (bus.bus_rdata_en || abort) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Bus and response outputs decode straight from flops, so they change only at clock edges.
    always_comb begin
        bus.bus_io_req  = 1'b0;
        bus.bus_wrt     = 1'b0;
        bus.bus_address = 16'h0000;
        bus.bus_wdata   = 8'h00;
        rsp_valid       = 1'b0;
        rsp_rdata       = 8'h00;
        rsp_error       = 1'b0;
        busy            = (count != '0) || (state != IDLE);
        case (state)
            ADDR_REQ: begin
                bus.bus_io_req  = 1'b1;
                bus.bus_wrt     = 1'b1;
                bus.bus_address = IO_BASE;
                bus.bus_wdata   = {4'd0, q_reg};
            end
            DATA_REQ: begin
                bus.bus_io_req  = 1'b1;
                bus.bus_wrt     = q_wrt;
                bus.bus_address = q_wrt ? IO_BASE + 16'd1 : IO_BASE + 16'd2;
                bus.bus_wdata   = q_wrt ? q_wdata : 8'h00;
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
`ifdef SSG_BUS_MASTER_TIMEOUT_EN
                rsp_error = err_q;
`endif
            end
            default: ;
        endcase
    end
endmodule
